// File: rtl/sym_pkg.sv
// Shared constants and helpers for the symmetry reconstruction stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sym_pkg;

    // Symmetry class of the activation function being folded back out.
    localparam int SYM_ODD     = 0;  // f(-x) = -f(x)      (tanh-like)
    localparam int SYM_SIGMOID = 1;  // f(-x) = 1 - f(x)   (sigmoid-like)
    localparam int SYM_EVEN    = 2;  // f(-x) = f(x)       (pass-through)

    // Saturating narrow: clamps a sign-extended value to the signed range
    // of 'width' bits. The caller keeps the low 'width' bits of the result.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] value,
                                                 input int                 width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi)
            sat_w = hi;
        else if (value < lo)
            sat_w = lo;
        else
            sat_w = value;
    endfunction

endpackage

// File: rtl/sym_sat.sv
// Combinational saturator: WIDTH+1-bit signed -> WIDTH-bit signed, clamps instead of wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
// Ports: din  - WIDTH+1-bit signed value from the fold logic
//        dout - WIDTH-bit signed saturated value
module sym_sat #(
    parameter int WIDTH = 12
) (
    input  logic signed [WIDTH:0]   din,
    output logic signed [WIDTH-1:0] dout
);
    import sym_pkg::*;

    logic signed [63:0] wide_in;
    logic signed [63:0] wide_sat;
    logic               unused_hi;

    assign wide_in  = {{(63 - WIDTH){din[WIDTH]}}, din};
    assign wide_sat = sat_w(wide_in, WIDTH);
    assign dout     = wide_sat[WIDTH-1:0];

    // Upper bits are copies of the sign after clamping; nothing downstream needs them.
    assign unused_hi = ^wide_sat[63:WIDTH];

endmodule

// File: rtl/sym.sv
// Symmetry reconstruction: folds half-range f(|x|) back to f(x) from the sign of x and the class of f.
// Latency: 1 cycle (single output register, synchronous active-high reset).
// Backpressure: none; accepts one sample every cycle, no valid/ready.
// Ports: clk   - rising-edge clock
//        rst   - synchronous reset, active-high, clears s_out
//        x_in  - signed Q(M.N) half-range value f(|x|)
//        sign  - original sign of x (1 = negative)
//        s_out - signed Q(M.N) reconstructed f(x), registered
module sym #(
    parameter int M         = 4,
    parameter int N         = 8,
    parameter int FUNC_TYPE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [M+N-1:0]     x_in,
    input  logic                      sign,
    output logic signed [M+N-1:0]     s_out
);
    import sym_pkg::*;

    localparam int WIDTH = M + N;

    logic signed [WIDTH:0]   ext;   // one guard bit so -min and 1-x cannot wrap
    logic signed [WIDTH:0]   fold;
    logic signed [WIDTH-1:0] sat;

    assign ext = {x_in[WIDTH-1], x_in};

    generate
        if (FUNC_TYPE == SYM_ODD) begin : g_odd
            assign fold = sign ? -ext : ext;
        end else if (FUNC_TYPE == SYM_SIGMOID) begin : g_sigmoid
            localparam logic signed [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1} << N;
            assign fold = sign ? (ONE - ext) : ext;
        end else begin : g_even
            // Even functions ignore the sign; unknown types fall here too.
            logic unused_sign;
            assign unused_sign = sign;
            assign fold        = ext;
        end
    endgenerate

    sym_sat #(
        .WIDTH (WIDTH)
    ) u_sat (
        .din  (fold),
        .dout (sat)
    );

    always_ff @(posedge clk) begin
        if (rst)
            s_out <= '0;
        else
            s_out <= sat;
    end

endmodule

// File: tb/tb_sym.sv
// Bench for sym: all three symmetry classes side by side, directed cases then random stream.
// Latency: checks output one edge after inputs, and that it holds until that edge.
// Backpressure: none in the DUT; bench drives one sample per cycle.
module tb_sym;

    localparam int M     = 4;
    localparam int N     = 8;
    localparam int WIDTH = M + N;

    logic                    clk;
    logic                    rst;
    logic signed [WIDTH-1:0] x_in;
    logic                    sign;
    logic signed [WIDTH-1:0] s0;
    logic signed [WIDTH-1:0] s1;
    logic signed [WIDTH-1:0] s2;

    int tests;
    int fails;
    int exp_q [3];
    bit have_prev;

    sym #(.M(M), .N(N), .FUNC_TYPE(0)) u_t0 (.clk(clk), .rst(rst), .x_in(x_in), .sign(sign), .s_out(s0));
    sym #(.M(M), .N(N), .FUNC_TYPE(1)) u_t1 (.clk(clk), .rst(rst), .x_in(x_in), .sign(sign), .s_out(s1));
    sym #(.M(M), .N(N), .FUNC_TYPE(2)) u_t2 (.clk(clk), .rst(rst), .x_in(x_in), .sign(sign), .s_out(s2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: f(-x) from f(|x|) by symmetry class, plain integer math then clamp.
    function automatic int model(input int t, input int x, input bit s);
        int v;
        int hi;
        int lo;
        hi = (1 << (WIDTH - 1)) - 1;
        lo = -(1 << (WIDTH - 1));
        if (!s)
            v = x;
        else if (t == 0)
            v = -x;
        else if (t == 1)
            v = (1 << N) - x;
        else
            v = x;
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v;
    endfunction

    task automatic chk(input string tag, input logic signed [WIDTH-1:0] obs, input int expv);
        logic signed [WIDTH-1:0] e;
        e = WIDTH'(expv);
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One cycle: inputs change on the falling edge, result checked just after the rising edge.
    task automatic step(input int x, input bit s, input bit r, input string tag);
        @(negedge clk);
        if (have_prev) begin
            chk({tag, "_hold_t0"}, s0, exp_q[0]);
            chk({tag, "_hold_t1"}, s1, exp_q[1]);
            chk({tag, "_hold_t2"}, s2, exp_q[2]);
        end
        x_in = WIDTH'(x);
        sign = s;
        rst  = r;
        for (int t = 0; t < 3; t++)
            exp_q[t] = r ? 0 : model(t, x, s);
        @(posedge clk);
        #1;
        chk({tag, "_t0"}, s0, exp_q[0]);
        chk({tag, "_t1"}, s1, exp_q[1]);
        chk({tag, "_t2"}, s2, exp_q[2]);
        have_prev = 1'b1;
    endtask

    initial begin
        int xv;
        bit sv;
        bit rv;
        tests     = 0;
        fails     = 0;
        have_prev = 1'b0;
        x_in      = '0;
        sign      = 1'b0;
        rst       = 1'b1;

        // Reset for two cycles with non-zero data present: output must stay 0.
        step(1234, 1'b1, 1'b1, "reset0");
        step(-77,  1'b1, 1'b1, "reset1");

        // Directed cases.
        step(50,    1'b0, 1'b0, "x50_pos");
        step(-100,  1'b1, 1'b0, "xm100_neg");
        step(77,    1'b1, 1'b0, "x77_neg");
        step(123,   1'b0, 1'b0, "x123_pos");
        step(-88,   1'b1, 1'b0, "xm88_neg");
        step(-2048, 1'b1, 1'b0, "sat_min_neg");
        step(2047,  1'b1, 1'b0, "sat_max_neg");
        step(-2048, 1'b0, 1'b0, "min_pos");
        step(2047,  1'b0, 1'b0, "max_pos");
        step(-1900, 1'b1, 1'b0, "sig_hi_sat");
        step(0,     1'b1, 1'b0, "zero_neg");

        // Mid-stream reset then immediate resume.
        step(300,   1'b1, 1'b0, "pre_rst");
        step(400,   1'b1, 1'b1, "mid_rst");
        step(-500,  1'b1, 1'b0, "post_rst");

        // Random stream, biased toward range ends, with occasional resets.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0:       xv = -2048 + int'($urandom_range(0, 3));
                1:       xv = 2047 - int'($urandom_range(0, 3));
                default: begin
                    xv = int'($urandom_range(0, 4095));
                    if (xv > 2047) xv -= 4096;
                end
            endcase
            sv = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 19) == 0);
            step(xv, sv, rv, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
